// File: rtl/ibuf_predecode.sv
// Instruction buffer between fetch and decode. Each entry is tagged as a control
// transfer on write, and a branch is only offered together with its delay slot.
module ibuf_predecode #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PUSH_W = 2,
    parameter int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            in_cnt,
    input  logic [32*PUSH_W-1:0]  in_pc,
    input  logic [32*PUSH_W-1:0]  in_inst,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_inst,
    output logic                  out_branch,
    output logic                  out_ds,
    input  logic                  flush,
    input  logic                  flush_keep_ds,
    output logic [CW-1:0]         count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic          mem_br   [DEPTH];

    logic [AW-1:0] rp, wp, rp_n, wp_n;
    logic [CW-1:0] count_q, count_n;
    logic          ds_pending, ds_pending_n;

    logic [1:0]    eff_cnt;
    logic [CW-1:0] push_n;
    logic          do_push;
    logic          pop;
    logic          head_br;

    // Control-transfer pre-decode: J/JAL/Bxx, REGIMM branches, JR/JALR.
    function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [5:0] fn);
        logic br;
        br = 1'b0;
        case (op)
            6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: br = 1'b1;
            6'd1: br = (rt == 5'd0) || (rt == 5'd1) || (rt == 5'd16) || (rt == 5'd17);
            6'd0: br = (fn == 6'd8) || (fn == 6'd9);
            default: br = 1'b0;
        endcase
        return br;
    endfunction

    // Outputs depend on registered state only.
    assign head_br    = mem_br[rp];
    assign count      = count_q;
    assign in_ready   = (count_q <= CW'(DEPTH - PUSH_W));
    assign out_valid  = (count_q != '0) && !(head_br && (count_q < CW'(2)));
    assign out_pc     = mem_pc[rp];
    assign out_inst   = mem_inst[rp];
    assign out_branch = out_valid && head_br;
    assign out_ds     = out_valid && ds_pending;

    assign eff_cnt = (32'(in_cnt) > PUSH_W) ? 2'(PUSH_W) : in_cnt;
    assign do_push = in_ready && !flush && (eff_cnt != 2'd0);
    assign push_n  = do_push ? CW'(eff_cnt) : '0;
    assign pop     = out_valid && out_ready;

    // Next pointers/occupancy; flush overrides push and may retain one delay slot.
    always_comb begin
        rp_n         = rp + AW'(pop);
        wp_n         = wp + AW'(push_n);
        count_n      = count_q + push_n - CW'(pop);
        ds_pending_n = pop ? head_br : ds_pending;
        if (flush) begin
            if (flush_keep_ds && pop && head_br) begin
                rp_n         = rp + AW'(1);
                wp_n         = rp + AW'(2);
                count_n      = CW'(1);
                ds_pending_n = 1'b1;
            end else if (flush_keep_ds && !pop && ds_pending) begin
                rp_n         = rp;
                wp_n         = rp + AW'(1);
                count_n      = CW'(1);
                ds_pending_n = 1'b1;
            end else begin
                rp_n         = wp;
                wp_n         = wp;
                count_n      = '0;
                ds_pending_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp         <= '0;
            wp         <= '0;
            count_q    <= '0;
            ds_pending <= 1'b0;
        end else begin
            rp         <= rp_n;
            wp         <= wp_n;
            count_q    <= count_n;
            ds_pending <= ds_pending_n;
        end
    end

    // Storage array carries no reset; slot 0 lands at wp, slot 1 at wp+1.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(PUSH_W); i++) begin
            if (do_push && (i < int'(eff_cnt))) begin
                mem_pc[wp + AW'(i)]   <= in_pc[32*i +: 32];
                mem_inst[wp + AW'(i)] <= in_inst[32*i +: 32];
                mem_br[wp + AW'(i)]   <= is_branch(in_inst[32*i+26 +: 6],
                                                   in_inst[32*i+16 +: 5],
                                                   in_inst[32*i +: 6]);
            end
        end
    end

endmodule

// File: doc/ibuf_predecode.md
# ibuf_predecode

Parametrised instruction buffer that sits between fetch and the decode stage. It accepts up to `PUSH_W` instructions per cycle and delivers one instruction per cycle to decode. Each instruction is pre-decoded for control transfer, so a branch and its delay slot are always offered to decode back-to-back. On a front-end redirect it flushes, and can optionally keep a pending delay slot.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥4.
- `PUSH_W`, 2, maximum instructions pushed per cycle; legal values 1 or 2.
- `CW`, $clog2(DEPTH)+1, width of the `count` output.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_cnt`  in  2  number of valid slots pushed this cycle (0..PUSH_W); slot 0 is older.
- `in_pc`  in  32*PUSH_W  PC per slot; slot i at [32i+31:32i].
- `in_inst`  in  32*PUSH_W  instruction word per slot, same packing.
- `in_ready`  out  1  high when free entries ≥ PUSH_W.
- `out_valid`  out  1  head entry is deliverable.
- `out_ready`  in  1  decode accepts the head entry.
- `out_pc`  out  32  PC of the head entry.
- `out_inst`  out  32  instruction word of the head entry.
- `out_branch`  out  1  head entry is a branch or jump.
- `out_ds`  out  1  head entry is the delay slot of the last popped branch.
- `flush`  in  1  discard buffered entries.
- `flush_keep_ds`  in  1  qualifies `flush`: retain a pending delay slot.
- `count`  out  CW  number of occupied entries.

## Operation
- Storage: circular array of {pc, inst, br}. Read pointer `rp`, write pointer `wp`, each log2(DEPTH) bits and wrapping modulo DEPTH. Occupancy is held in `count`.
- Push is accepted when `in_ready` is high. Slots 0..in_cnt-1 are written at wp, wp+1 (in order), and wp advances by in_cnt. If `in_ready` is low, the push is ignored; fetch must hold it.
- Pre-decode (`br`), computed at write from the instruction's opcode [31:26]:
  - opcode 2..7 (J, JAL, BEQ, BNE, BLEZ, BGTZ);
  - opcode 1 with rt [20:16] ∈ {0, 1, 16, 17};
  - opcode 0 with func [5:0] ∈ {8, 9} (JR/JALR).
- Pair rule: `out_valid` = count≥1 AND NOT(head.br AND count<2). A branch is never offered until its delay slot is buffered.
- Pop happens when out_valid & out_ready; rp advances by 1.
- `ds_pending` register: on a pop it is set to the popped entry's br. It is cleared on flush when no entry is kept. `out_ds` = ds_pending & out_valid.
- Simultaneous push and pop: count' = count + in_cnt − pop.
- Flush has priority over push in the same cycle; the push is dropped.
  - Plain flush (`flush_keep_ds`=0): count←0, rp←wp, ds_pending←0.
  - `flush_keep_ds`=1, no pop this cycle, ds_pending=1: keep the entry at rp; count←1, wp←rp+1.
  - `flush_keep_ds`=1 with a pop of a branch this cycle: the pop completes, the entry at rp+1 is kept, count←1, ds_pending←1.
  - Any other `flush_keep_ds` case: same as a plain flush.
- Reset (async): rp=wp=0, count=0, ds_pending=0. Array contents are don't-care.

## Timing
- Output reset values: in_ready=1, out_valid=0, out_branch=0, out_ds=0, count=0. out_pc and out_inst are don't-care while out_valid=0.
- Push-to-output latency is 1 cycle: an entry written at edge N is visible on out_* after edge N. There is no bypass.
- out_* and `in_ready` are combinational from registered state only. They never depend on `in_cnt`, `flush` or `out_ready` in the same cycle.
- `count` reaches DEPTH maximum. in_ready falls when count > DEPTH−PUSH_W, for example at count 7 when DEPTH=8 and PUSH_W=2.
- Empty: out_valid=0, and out_ready is ignored.
- Pointer wrap: wp/rp roll from DEPTH−1 to 0 with no bubble. A 2-wide push may straddle the wrap.
- Reset mid-operation: all outputs take their reset values immediately (asynchronously). The first push after deassertion appears 1 cycle later.

## Test plan
- After reset, push two ADDU (pc 0x100, 0x104) in one cycle with out_ready=1 → out_pc is 0x100 on the next cycle and 0x104 on the one after; out_branch=0 and out_ds=0; count goes 2→1→0.
- DEPTH=8, PUSH_W=2, out_ready=0, push 2 per cycle → count 2, 4, 6, 8. in_ready drops once count=8; a push presented while in_ready=0 leaves count at 8.
- Push BEQ 0x10220003 alone → out_valid stays 0. Push its delay slot next cycle → out_valid=1, out_branch=1. After the pop, the head shows out_ds=1.
- 3 entries buffered with head = BNE; pop BNE while asserting flush with flush_keep_ds=1 → count=1, head is the delay slot with out_ds=1. Repeat with flush_keep_ds=0 → count=0, out_valid=0.
- Push and pop continuously for 40 instructions with pc incrementing by 4 → no loss, reorder or duplication across several wraps, including a wrap inside a 2-wide push.
- Assert rst asynchronously (mid-cycle) with count=5 → count=0, out_valid=0 and in_ready=1 before the next edge. A push after release appears 1 cycle later.
